dmem_access_unit: RTL

Byte-addressed load/store front end sitting directly upstream of the SPRAM-backed `data_memory` word store. It converts RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into whole-word `memread`/`memwrite` strobes. Sub-word stores use read-modify-write, because the memory's write mask is fixed to all nibbles. It also sign- or zero-extends load results, and flags misaligned or illegal accesses without touching memory.

---
 rtl/dmem_access_unit_if.sv | 41 ++++
 rtl/dmem_access_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dmem_access_unit_if
// Description : Request/response bus of the data-memory access unit plus the
//               word-wide strobes towards the SPRAM-backed data_memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_access_unit_if;
  // requester side
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  // memory side
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [31:0] mem_read_data;

  // the access unit itself
  modport slave (
    input  req, we, funct3, addr, wdata, mem_read_data,
    output ready, done, err, rdata,
           mem_addr, mem_write_data, mem_memwrite, mem_memread
  );

  // the environment: requester plus memory
  modport master (
    output req, we, funct3, addr, wdata, mem_read_data,
    input  ready, done, err, rdata,
           mem_addr, mem_write_data, mem_memwrite, mem_memread
  );
endinterface
`default_nettype wire

// File: rtl/dmem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dmem_access_unit
// Description : RV32I byte-addressed load/store front end for a whole-word
//               SPRAM. Sub-word stores are done as read-modify-write; loads
//               are sign/zero extended; misaligned/illegal accesses complete
//               with err and never touch memory.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_unit #(
  parameter int ADDR_BITS = 14
) (
  input  logic               clk,
  input  logic               rst,
  dmem_access_unit_if.slave  bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD      = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;
  localparam logic [1:0] S_WR      = 2'd3;

  localparam logic [2:0] c_F3_B  = 3'b000;
  localparam logic [2:0] c_F3_H  = 3'b001;
  localparam logic [2:0] c_F3_W  = 3'b010;
  localparam logic [2:0] c_F3_BU = 3'b100;
  localparam logic [2:0] c_F3_HU = 3'b101;

  logic [1:0]           r_state;
  logic [1:0]           w_next;
  logic                 r_we;
  logic [2:0]           r_f3;
  logic [ADDR_BITS+1:0] r_addr;
  logic [31:0]          r_wdata;
  logic                 r_done;
  logic                 r_err;
  logic [31:0]          r_rdata;
  logic [31:0]          r_mem_wdata;

  logic                 w_accept;
  logic                 w_legal;
  logic                 w_aligned;
  logic                 w_bad;
  logic                 w_is_sw;
  logic                 w_ready;
  logic                 w_memread;
  logic                 w_memwrite;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [31:0]          w_load;
  logic [31:0]          w_merge;

  assign w_accept = bus.req && (r_state == S_IDLE);
  assign w_is_sw  = bus.we && (bus.funct3 == c_F3_W);
  assign w_bad    = !(w_legal && w_aligned);

  // Decode legality and alignment of the request presented at the inputs
  always_comb begin
    if (bus.we)
      w_legal = bus.funct3 inside {c_F3_B, c_F3_H, c_F3_W};
    else
      w_legal = bus.funct3 inside {c_F3_B, c_F3_H, c_F3_W, c_F3_BU, c_F3_HU};
    case (bus.funct3[1:0])
      2'b01:   w_aligned = (bus.addr[0] == 1'b0);
      2'b10:   w_aligned = (bus.addr[1:0] == 2'b00);
      default: w_aligned = 1'b1;
    endcase
  end

  // State register; reset aborts any access and drops the strobes at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: errors complete in IDLE, SW skips the read phase
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_bad) w_next = w_is_sw ? S_WR : S_RD;
      end
      S_RD:      w_next = S_RD_WAIT;
      S_RD_WAIT: w_next = r_we ? S_WR : S_IDLE;
      S_WR:      w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Strobes and ready are pure functions of the state, so they are exclusive
  always_comb begin
    w_ready    = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    case (r_state)
      S_IDLE:  w_ready    = 1'b1;
      S_RD:    w_memread  = 1'b1;
      S_WR:    w_memwrite = 1'b1;
      default: ;
    endcase
  end

  // Lane extraction and extension of the word returned by memory
  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = bus.mem_read_data[7:0];
      2'd1:    w_byte = bus.mem_read_data[15:8];
      2'd2:    w_byte = bus.mem_read_data[23:16];
      default: w_byte = bus.mem_read_data[31:24];
    endcase
    w_half = r_addr[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
    case (r_f3)
      c_F3_B:  w_load = {{24{w_byte[7]}}, w_byte};
      c_F3_H:  w_load = {{16{w_half[15]}}, w_half};
      c_F3_BU: w_load = {24'd0, w_byte};
      c_F3_HU: w_load = {16'd0, w_half};
      default: w_load = bus.mem_read_data;
    endcase
  end

  // Insert the store lanes of the latched data into the word just read
  always_comb begin
    w_merge = bus.mem_read_data;
    if (r_f3 == c_F3_B)
      w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    else
      w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
  end

  // Request latch, load result, RMW write word and the completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we        <= 1'b0;
      r_f3        <= 3'd0;
      r_addr      <= '0;
      r_wdata     <= 32'd0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 32'd0;
      r_mem_wdata <= 32'd0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we    <= bus.we;
            r_f3    <= bus.funct3;
            r_addr  <= bus.addr[ADDR_BITS+1:0];
            r_wdata <= bus.wdata;
            if (w_bad) begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end else if (w_is_sw) begin
              r_mem_wdata <= bus.wdata;
            end
          end
        end
        S_RD_WAIT: begin
          if (r_we) begin
            r_mem_wdata <= w_merge;
          end else begin
            r_rdata <= w_load;
            r_done  <= 1'b1;
          end
        end
        S_WR:    r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.ready          = w_ready;
  assign bus.done           = r_done;
  assign bus.err            = r_err;
  assign bus.rdata          = r_rdata;
  assign bus.mem_addr       = {{(32-ADDR_BITS){1'b0}}, r_addr[ADDR_BITS+1:2]};
  assign bus.mem_write_data = r_mem_wdata;
  assign bus.mem_memread    = w_memread;
  assign bus.mem_memwrite   = w_memwrite;

endmodule
`default_nettype wire
